// File: rtl/tl_cfg_sequencer.sv
// -----------------------------------------------------------------------------
// tl_cfg_sequencer
//
// Upstream configuration sequencer for the traffic-light controller. The host
// fills three shadow phase-duration registers (addresses 1..3). A `go` pulse
// programs them into the controller through its cs/write/addr/wr_data register
// port, optionally reads them back, then raises the controller `start` level.
//
// Build option:
//   TL_CFG_VERIFY_EN  - when defined, a readback pass (RD_ADDR/RD_SAMPLE/RD_GAP)
//                       follows programming and a mismatch parks the sequencer
//                       in ERROR with `err` set. When undefined, `rd_data` is
//                       ignored, `err` is tied low and the last write gap goes
//                       straight to RUN.
//
// Parameters:
//   DW   register data width
//   AW   register address width
//   GAP  idle (cs=0) cycles after every bus access, 1..3
//
// Ports:
//   clk, reset            single clock, asynchronous active-high reset
//   cmd_valid/cmd_ready   host shadow-write handshake (cmd_ready combinational)
//   cmd_addr, cmd_data    shadow index (1..3 stored, 0 discarded) and data
//   go, stop              single-cycle sequence start / abort pulses
//   busy                  programming or verifying in progress
//   done                  one-cycle pulse on the cycle `start` rises
//   err                   sticky readback mismatch flag
//   cs, write, addr,
//   wr_data               controller register port (registered)
//   rd_data               controller read data, valid one cycle after a read
//   start                 controller run enable (level)
// -----------------------------------------------------------------------------
module tl_cfg_sequencer #(
  parameter int DW  = 4,
  parameter int AW  = 2,
  parameter int GAP = 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [AW-1:0] cmd_addr,
  input  logic [DW-1:0] cmd_data,
  input  logic          go,
  input  logic          stop,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic          cs,
  output logic          write,
  output logic [AW-1:0] addr,
  output logic [DW-1:0] wr_data,
  input  logic [DW-1:0] rd_data,
  output logic          start
);

  // Gap counter loads GAP-1 on entry to a gap state and leaves at zero,
  // which yields exactly GAP idle cycles.
  localparam logic [1:0] GAP_LAST  = 2'(GAP - 1);
  localparam logic [1:0] IDX_FIRST = 2'd1;
  localparam logic [1:0] IDX_LAST  = 2'd3;

  typedef enum logic [3:0] {
    ST_IDLE      = 4'd0,
    ST_WR_SETUP  = 4'd1,
    ST_WR_STROBE = 4'd2,
    ST_WR_GAP    = 4'd3,
    ST_RUN       = 4'd4
`ifdef TL_CFG_VERIFY_EN
    ,
    ST_RD_ADDR   = 4'd5,
    ST_RD_SAMPLE = 4'd6,
    ST_RD_GAP    = 4'd7,
    ST_ERROR     = 4'd8
`endif
  } state_t;

  // Select one of the three shadow values by index; index 0 never occurs
  // while sequencing and falls back to the first register.
  function automatic logic [DW-1:0] pick_shadow(
    input logic [1:0]    idx,
    input logic [DW-1:0] s1,
    input logic [DW-1:0] s2,
    input logic [DW-1:0] s3
  );
    logic [DW-1:0] val;
    case (idx)
      2'd2:    val = s2;
      2'd3:    val = s3;
      default: val = s1;
    endcase
    return val;
  endfunction

  // Register index to bus address (zero-extended for wider address buses).
  function automatic logic [AW-1:0] idx_to_addr(input logic [1:0] idx);
    return AW'(idx);
  endfunction

  state_t        state_r;
  logic [1:0]    idx_r;
  logic [1:0]    gap_r;
  logic [1:0]    idx_inc_s;
  logic [DW-1:0] sh_r     [1:3];
  logic [DW-1:0] sh_nxt_s [1:3];
  logic [DW-1:0] sh_inc_s;
  logic          cmd_ready_s;
  logic          wr_en_s;

  logic          cs_r;
  logic          write_r;
  logic [AW-1:0] addr_r;
  logic [DW-1:0] wr_data_r;
  logic          start_r;
  logic          busy_r;
  logic          done_r;

`ifdef TL_CFG_VERIFY_EN
  logic          err_r;
  logic [DW-1:0] sh_cur_s;
`else
  logic          rd_data_unused_s;
`endif

  // Shadow writes are only accepted while the bus sequence is not running.
  always_comb begin
    case (state_r)
      ST_IDLE:  cmd_ready_s = 1'b1;
      ST_RUN:   cmd_ready_s = 1'b1;
`ifdef TL_CFG_VERIFY_EN
      ST_ERROR: cmd_ready_s = 1'b1;
`endif
      default:  cmd_ready_s = 1'b0;
    endcase
  end

  assign wr_en_s = cmd_valid & cmd_ready_s;

  // Shadow contents as they will be after this edge. The launch from IDLE
  // reads these so a write coinciding with `go` is the value programmed.
  always_comb begin
    for (int k = 1; k <= 3; k++) begin
      if (wr_en_s && (cmd_addr == AW'(k))) begin
        sh_nxt_s[k] = cmd_data;
      end else begin
        sh_nxt_s[k] = sh_r[k];
      end
    end
  end

  // Value for the next index while stepping through writes or reads.
  always_comb begin
    idx_inc_s = idx_r + 2'd1;
    sh_inc_s  = pick_shadow(idx_inc_s, sh_r[1], sh_r[2], sh_r[3]);
  end

`ifdef TL_CFG_VERIFY_EN
  // Expected readback for the register currently being verified.
  always_comb begin
    sh_cur_s = pick_shadow(idx_r, sh_r[1], sh_r[2], sh_r[3]);
  end
`else
  // Readback data has no consumer without verification.
  assign rd_data_unused_s = ^rd_data;
`endif

  // Shadow register storage.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 1; k <= 3; k++) begin
        sh_r[k] <= {DW{1'b0}};
      end
    end else begin
      for (int k = 1; k <= 3; k++) begin
        sh_r[k] <= sh_nxt_s[k];
      end
    end
  end

  // Sequencer FSM: state, index, gap count and all registered outputs.
  // Outputs are assigned for the state being entered so they line up with it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r   <= ST_IDLE;
      idx_r     <= 2'd0;
      gap_r     <= 2'd0;
      cs_r      <= 1'b0;
      write_r   <= 1'b0;
      addr_r    <= {AW{1'b0}};
      wr_data_r <= {DW{1'b0}};
      start_r   <= 1'b0;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
`ifdef TL_CFG_VERIFY_EN
      err_r     <= 1'b0;
`endif
    end else begin
      done_r <= 1'b0;
      if (stop && (state_r != ST_IDLE)) begin
        // Abort from any active state: bus idle and start low next cycle.
        state_r <= ST_IDLE;
        cs_r    <= 1'b0;
        write_r <= 1'b0;
        start_r <= 1'b0;
        busy_r  <= 1'b0;
      end else begin
        case (state_r)
          ST_IDLE: begin
            if (go) begin
              state_r   <= ST_WR_SETUP;
              idx_r     <= IDX_FIRST;
              cs_r      <= 1'b1;
              write_r   <= 1'b0;
              addr_r    <= idx_to_addr(IDX_FIRST);
              wr_data_r <= sh_nxt_s[1];
              busy_r    <= 1'b1;
`ifdef TL_CFG_VERIFY_EN
              err_r     <= 1'b0;
`endif
            end else begin
              state_r <= ST_IDLE;
            end
          end

          ST_WR_SETUP: begin
            state_r <= ST_WR_STROBE;
            write_r <= 1'b1;
          end

          ST_WR_STROBE: begin
            state_r <= ST_WR_GAP;
            cs_r    <= 1'b0;
            write_r <= 1'b0;
            gap_r   <= GAP_LAST;
          end

          ST_WR_GAP: begin
            if (gap_r != 2'd0) begin
              gap_r <= gap_r - 2'd1;
            end else if (idx_r == IDX_LAST) begin
`ifdef TL_CFG_VERIFY_EN
              state_r <= ST_RD_ADDR;
              idx_r   <= IDX_FIRST;
              cs_r    <= 1'b1;
              addr_r  <= idx_to_addr(IDX_FIRST);
`else
              state_r <= ST_RUN;
              start_r <= 1'b1;
              done_r  <= 1'b1;
              busy_r  <= 1'b0;
`endif
            end else begin
              state_r   <= ST_WR_SETUP;
              idx_r     <= idx_inc_s;
              cs_r      <= 1'b1;
              addr_r    <= idx_to_addr(idx_inc_s);
              wr_data_r <= sh_inc_s;
            end
          end

`ifdef TL_CFG_VERIFY_EN
          ST_RD_ADDR: begin
            // cs stays high through RD_SAMPLE; data returns a cycle later.
            state_r <= ST_RD_SAMPLE;
          end

          ST_RD_SAMPLE: begin
            cs_r <= 1'b0;
            if (rd_data != sh_cur_s) begin
              state_r <= ST_ERROR;
              err_r   <= 1'b1;
              busy_r  <= 1'b0;
            end else begin
              state_r <= ST_RD_GAP;
              gap_r   <= GAP_LAST;
            end
          end

          ST_RD_GAP: begin
            if (gap_r != 2'd0) begin
              gap_r <= gap_r - 2'd1;
            end else if (idx_r == IDX_LAST) begin
              state_r <= ST_RUN;
              start_r <= 1'b1;
              done_r  <= 1'b1;
              busy_r  <= 1'b0;
            end else begin
              state_r <= ST_RD_ADDR;
              idx_r   <= idx_inc_s;
              cs_r    <= 1'b1;
              addr_r  <= idx_to_addr(idx_inc_s);
            end
          end

          ST_ERROR: begin
            // Retry clears the sticky error; stop is handled above.
            if (go) begin
              state_r   <= ST_WR_SETUP;
              idx_r     <= IDX_FIRST;
              cs_r      <= 1'b1;
              write_r   <= 1'b0;
              addr_r    <= idx_to_addr(IDX_FIRST);
              wr_data_r <= sh_nxt_s[1];
              busy_r    <= 1'b1;
              err_r     <= 1'b0;
            end else begin
              state_r <= ST_ERROR;
            end
          end
`endif

          ST_RUN: begin
            // Held until stop; go is ignored here.
            state_r <= ST_RUN;
          end

          default: begin
            state_r <= ST_IDLE;
            cs_r    <= 1'b0;
            write_r <= 1'b0;
            start_r <= 1'b0;
            busy_r  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign cmd_ready = cmd_ready_s;
  assign cs        = cs_r;
  assign write     = write_r;
  assign addr      = addr_r;
  assign wr_data   = wr_data_r;
  assign start     = start_r;
  assign busy      = busy_r;
  assign done      = done_r;
`ifdef TL_CFG_VERIFY_EN
  assign err       = err_r;
`else
  assign err       = 1'b0;
`endif

endmodule

// File: doc/tl_cfg_sequencer.md
# tl_cfg_sequencer

Upstream configuration sequencer for the traffic-light controller. It holds host-written shadow copies of the three phase-duration registers (addresses 1..3). On a `go` request it programs them into the controller through the controller's `cs`/`write`/`addr`/`wr_data` register port, optionally reads them back, then drives the controller's `start` input. It replaces the hand-written register sequence in benches and is the block that drives the controller at integration.

## Interface
- `DW`, default 4: register data width; matches controller `wr_data`/`rd_data`.
- `AW`, default 2: register address width.
- `GAP`, default 1: idle cycles (`cs`=0) inserted after every bus access, range 1..3.
- `clk` in 1: single clock; all logic is on its rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `cmd_valid` in 1: host shadow-write request.
- `cmd_ready` out 1: sequencer can accept a shadow write.
- `cmd_addr` in AW: shadow register index; 1..3 are valid.
- `cmd_data` in DW: shadow write data.
- `go` in 1: single-cycle pulse; starts the program/verify/run sequence.
- `stop` in 1: single-cycle pulse; deasserts `start` and returns to IDLE.
- `busy` out 1: sequence in progress (programming or verifying).
- `done` out 1: one-cycle pulse when `start` rises.
- `err` out 1: sticky readback mismatch flag.
- `cs`, `write` out 1 each: controller register port strobes.
- `addr` out AW: controller register address.
- `wr_data` out DW: controller write data.
- `rd_data` in DW: controller read data; valid one cycle after `cs`=1 with `write`=0.
- `start` out 1: controller run enable; held as a level.

## Operation
- Shadow regs `sh[1..3]` reset to 0. A handshake (`cmd_valid` && `cmd_ready`) with `cmd_addr` 1..3 writes `sh[cmd_addr]`. Address 0 is accepted and discarded.
- `cmd_ready` = 1 in IDLE, RUN and ERROR, and 0 otherwise. Shadow writes in RUN do not reach the controller until the next `go`.
- FSM states: IDLE, WR_SETUP, WR_STROBE, WR_GAP, RD_ADDR, RD_SAMPLE, RD_GAP, RUN, ERROR. Index `i` runs 1..3.
- IDLE or ERROR, on `go`: clear `err`, set `i`=1, go to WR_SETUP. `go` in any other state is ignored.
- WR_SETUP: `cs`=1, `write`=0, `addr`=`i`, `wr_data`=`sh[i]`. Next state is WR_STROBE.
- WR_STROBE: same as WR_SETUP but with `write`=1. Next state is WR_GAP.
- WR_GAP: `cs`=`write`=0 for GAP cycles. Then `i`++ and back to WR_SETUP, or after `i`=3 go to RD_ADDR (if verify is compiled in) or to RUN.
- RD_ADDR: `cs`=1, `write`=0, `addr`=`i`. Next state is RD_SAMPLE.
- RD_SAMPLE: `cs`=1. Compare `rd_data` with `sh[i]`. On mismatch set `err` and go to ERROR. On match go to RD_GAP.
- RD_GAP: GAP idle cycles. Then the next `i`, or after `i`=3 go to RUN.
- RUN: `start`=1. `done` pulses on the entry cycle. `stop` returns to IDLE with `start`=0.
- ERROR: `start`=0, bus idle. Leaves on `go` (retry) or `stop` (to IDLE, `err` stays set until the next `go`).
- `stop` in any busy state aborts the sequence: go to IDLE, bus idle next cycle, `start`=0.
- `go` and a shadow write in the same IDLE cycle: the write lands first, and the new value is programmed.
- `busy` = 1 in the WR_* and RD_* states.

## Timing
- All outputs are registered except `cmd_ready`. Reset values: `cs`=`write`=0, `addr`=0, `wr_data`=0, `start`=0, `busy`=0, `done`=0, `err`=0. `cmd_ready`=1 (state IDLE).
- `go` sampled at edge N: `cs`=1 with `addr`=1 in cycle N+1, and `write`=1 in cycle N+2.
- Each write takes 2+GAP cycles. Each read takes 2+GAP cycles, with `rd_data` sampled at the end of RD_SAMPLE.
- With GAP=1: `start` rises 9 cycles after `go` without verify, and 18 cycles after with verify.
- Asserting `reset` mid-sequence forces IDLE and all reset values immediately, without waiting for a clock edge.

## Configuration
- `TL_CFG_VERIFY_EN` defined: the RD_* states and the ERROR state are present, and readback is compared as described above.
- Not defined: no RD_* states or ERROR state, `rd_data` is ignored, `err` is tied to 0, and WR_GAP of `i`=3 goes directly to RUN.

## Test plan
- Reset, write `sh` = {5, 10, 15}, pulse `go`. Bus shows (1,5), (2,10), (3,15), each as a setup cycle then a strobe cycle, with GAP idle cycles between. The controller model echoes the values, `start`=1 at `go`+18, `done` pulses once.
- Controller model returns 9 for addr 2 with verify on: `err`=1 after the addr-2 RD_SAMPLE, `start` stays 0, and the addr-3 write has already completed.
- `stop` pulse during WR_STROBE of `i`=2: `cs`=`write`=0 the next cycle, state IDLE, `start` never rises.
- `cmd_valid` with addr 0 and data 7: accepted, and no shadow changes. `go` in the same cycle as a write of 3 to addr 1: the bus writes 3 to addr 1.
- In RUN, write `sh[1]`=2: no bus activity and `start` stays 1. Then `stop` followed by `go` reprograms addr 1 with 2.
- Assert `reset` asynchronously mid-RD_ADDR: all outputs drop to their reset values before the next clock edge.
